// File: rtl/toy_lsu_wb_arbiter_pkg.sv
// toy_lsu_wb_arbiter_pkg: shared types and defaults for the LSU load writeback arbiter
package toy_lsu_wb_arbiter_pkg;
  typedef enum logic {WB_SRC_TCM, WB_SRC_DCACHE} lsu_wb_src_e;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } mem_ack_pkg;
  localparam int LSU_WB_FIFO_DEPTH = 4;
  localparam int LSU_WB_STARVE_MAX = 8;
  function automatic mem_ack_pkg mem_ack_make(input logic [4:0] rd, input logic [31:0] data);
    return '{rd: rd, data: data};
  endfunction
endpackage

// File: rtl/toy_lsu_wb_arbiter_fifo.sv
// toy_lsu_ack_fifo: synchronous FIFO with clear, buffers dcache acks
module toy_lsu_ack_fifo #(
  parameter int DEPTH = 4,
  parameter type T = logic [31:0]
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  T                         din,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  T mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_q];
  assign count   = cnt_q;
  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/toy_lsu_wb_arbiter.sv
// toy_lsu_wb_arbiter: merges DTCM and dcache load acks into one registered writeback port
module toy_lsu_wb_arbiter
  import toy_lsu_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = LSU_WB_FIFO_DEPTH,
  parameter int STARVE_MAX = LSU_WB_STARVE_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_en,
  input  logic        tcm_en,
  input  mem_ack_pkg  tcm_pld,
  input  logic        dcache_vld,
  input  mem_ack_pkg  dcache_pld,
  output logic        dcache_rdy,
  output logic        tcm_hold,
  output logic        wb_vld,
  output mem_ack_pkg  wb_pld,
  output lsu_wb_src_e wb_src
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] count, cnt_nxt;
  logic full, empty, acc, push, pop;
  mem_ack_pkg head, wb_pld_q, wb_pld_d;
  lsu_wb_src_e wb_src_q, wb_src_d;
  logic wb_vld_q, wb_vld_d, hold_q, hold_d;
  logic [SW-1:0] starve_q, starve_d;
  toy_lsu_ack_fifo #(.DEPTH(FIFO_DEPTH), .T(mem_ack_pkg)) u_fifo (
    .clk(clk), .rst(rst), .clr(flush_en), .push(push), .pop(pop), .din(dcache_pld),
    .head(head), .count(count), .full(full), .empty(empty)
  );
  assign dcache_rdy = ~full;
  assign acc  = dcache_vld & dcache_rdy;
  // dcache acks only bypass the FIFO when nothing older is waiting and DTCM is idle
  assign push = ~flush_en & acc & (tcm_en | ~empty);
  assign pop  = ~flush_en & ~tcm_en & ~empty;
  assign cnt_nxt = count + CW'(push) - CW'(pop);
  always_comb begin
    wb_vld_d = ~flush_en & (tcm_en | ~empty | acc);
    wb_pld_d = flush_en ? wb_pld_q : tcm_en ? tcm_pld : ~empty ? head : acc ? dcache_pld : wb_pld_q;
    wb_src_d = flush_en ? wb_src_q : tcm_en ? WB_SRC_TCM : (~empty | acc) ? WB_SRC_DCACHE : wb_src_q;
    starve_d = (flush_en | empty | ~tcm_en) ? '0 :
               (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1);
    // once raised, hold persists until the FIFO fully drains
    hold_d   = ~flush_en & ((starve_d == SW'(STARVE_MAX)) | (hold_q & (cnt_nxt != '0)));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_vld_q <= 1'b0;
      wb_pld_q <= '0;
      wb_src_q <= WB_SRC_TCM;
      starve_q <= '0;
      hold_q   <= 1'b0;
    end else begin
      wb_vld_q <= wb_vld_d;
      wb_pld_q <= wb_pld_d;
      wb_src_q <= wb_src_d;
      starve_q <= starve_d;
      hold_q   <= hold_d;
    end
  end
  assign wb_vld   = wb_vld_q;
  assign wb_pld   = wb_pld_q;
  assign wb_src   = wb_src_q;
  assign tcm_hold = hold_q;
endmodule

// File: tb/tb_toy_lsu_wb_arbiter.sv
// tb_toy_lsu_wb_arbiter: table vectors plus queue scoreboard for the writeback arbiter
module tb_toy_lsu_wb_arbiter;
  import toy_lsu_wb_arbiter_pkg::*;
  logic clk = 1'b0, rst = 1'b1, flush_en = 1'b0, tcm_en = 1'b0, dcache_vld = 1'b0;
  mem_ack_pkg tcm_pld = '0, dcache_pld = '0, wb_pld;
  logic dcache_rdy, tcm_hold, wb_vld;
  lsu_wb_src_e wb_src;
  always #5 clk = ~clk;
  toy_lsu_wb_arbiter dut (
    .clk(clk), .rst(rst), .flush_en(flush_en), .tcm_en(tcm_en), .tcm_pld(tcm_pld),
    .dcache_vld(dcache_vld), .dcache_pld(dcache_pld), .dcache_rdy(dcache_rdy),
    .tcm_hold(tcm_hold), .wb_vld(wb_vld), .wb_pld(wb_pld), .wb_src(wb_src)
  );
  typedef struct {mem_ack_pkg pld; lsu_wb_src_e src;} wb_t;
  typedef struct {
    logic r, t; logic [31:0] tp; logic dv; logic [31:0] dp; logic fl;
    logic e_vld; logic [31:0] e_data; lsu_wb_src_e e_src; logic e_rdy, e_hold;
  } vec_t;
  int total = 0, bad = 0;
  wb_t sb[$];
  mem_ack_pkg mq[$];
  vec_t vt[13];
  function automatic mem_ack_pkg mk(input logic [31:0] d);
    return mem_ack_make(d[4:0], d);
  endfunction
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic t, input mem_ack_pkg tp, input logic dv,
                      input mem_ack_pkg dp, input logic fl);
    bit acc, ev;
    wb_t e;
    mem_ack_pkg h;
    @(negedge clk);
    rst = r; tcm_en = t; tcm_pld = tp; dcache_vld = dv; dcache_pld = dp; flush_en = fl;
    #1;
    if (!r) chk("rdy", dcache_rdy, 64'(mq.size() < 4));
    acc = dv && mq.size() < 4;
    ev = 0;
    if (r || fl) mq.delete();
    else if (t) begin
      sb.push_back('{tp, WB_SRC_TCM}); ev = 1;
      if (acc) mq.push_back(dp);
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      sb.push_back('{h, WB_SRC_DCACHE}); ev = 1;
      if (acc) mq.push_back(dp);
    end else if (acc) begin
      sb.push_back('{dp, WB_SRC_DCACHE}); ev = 1;
    end
    @(posedge clk);
    #1;
    chk("wb_vld", wb_vld, 64'(ev));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("wb_pld", wb_pld, 64'(e.pld));
      chk("wb_src", wb_src, 64'(e.src));
    end
  endtask
  initial begin
    bit a;
    int k;
    vt[0]  = '{1'b1, 1'b1, 32'h1,  1'b1, 32'h2,  1'b0, 1'b0, 32'h0,  WB_SRC_TCM,    1'b1, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 32'h1,  1'b1, 32'h2,  1'b0, 1'b0, 32'h0,  WB_SRC_TCM,    1'b1, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  WB_SRC_TCM,    1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'hA,  1'b0, 1'b1, 32'hA,  WB_SRC_DCACHE, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 32'h70, 1'b1, 32'hD0, 1'b0, 1'b1, 32'h70, WB_SRC_TCM,    1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b1, 32'hD0, WB_SRC_DCACHE, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0, 32'hD0, WB_SRC_DCACHE, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 32'h71, 1'b1, 32'hE1, 1'b0, 1'b1, 32'h71, WB_SRC_TCM,    1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 32'h72, 1'b1, 32'hE2, 1'b0, 1'b1, 32'h72, WB_SRC_TCM,    1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 32'h73, 1'b1, 32'hE3, 1'b0, 1'b1, 32'h73, WB_SRC_TCM,    1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b1, 32'h74, 1'b1, 32'hE4, 1'b1, 1'b0, 32'h73, WB_SRC_TCM,    1'b1, 1'b0};
    vt[11] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0, 32'h73, WB_SRC_TCM,    1'b1, 1'b0};
    vt[12] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0, 32'h73, WB_SRC_TCM,    1'b1, 1'b0};
    for (int i = 0; i < 13; i++) begin
      step(vt[i].r, vt[i].t, mk(vt[i].tp), vt[i].dv, mk(vt[i].dp), vt[i].fl);
      chk($sformatf("t%0d_vld", i), wb_vld, 64'(vt[i].e_vld));
      chk($sformatf("t%0d_pld", i), wb_pld, 64'(mk(vt[i].e_data)));
      if (vt[i].e_vld || vt[i].r) chk($sformatf("t%0d_src", i), wb_src, 64'(vt[i].e_src));
      chk($sformatf("t%0d_rdy", i), dcache_rdy, 64'(vt[i].e_rdy));
      chk($sformatf("t%0d_hold", i), tcm_hold, 64'(vt[i].e_hold));
    end
    k = 0;
    for (int i = 0; i < 10; i++) begin
      a = dcache_rdy;
      step(1'b0, 1'b1, mk(32'h100 + i), k < 6, mk(32'h200 + k), 1'b0);
      if (a && k < 6) k++;
      chk("full_rdy", dcache_rdy, 64'(i < 3));
    end
    for (int c = 0; c < 30 && (k < 6 || mq.size() > 0); c++) begin
      a = dcache_rdy;
      step(1'b0, 1'b0, '0, k < 6, mk(32'h200 + k), 1'b0);
      if (a && k < 6) k++;
    end
    chk("full_drained", 64'(k == 6 && mq.size() == 0), 64'(1));
    chk("full_post_hold", tcm_hold, 64'(0));
    chk("full_post_rdy", dcache_rdy, 64'(1));
    step(1'b0, 1'b1, mk(32'h400), 1'b1, mk(32'h300), 1'b0);
    for (int n = 1; n <= 10; n++) begin
      step(1'b0, 1'b1, mk(32'h400 + n), 1'b0, '0, 1'b0);
      chk($sformatf("starve_hold%0d", n), tcm_hold, 64'(n >= 8));
    end
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    chk("starve_pop_pld", wb_pld, 64'(mk(32'h300)));
    chk("starve_release", tcm_hold, 64'(0));
    chk("starve_rdy", dcache_rdy, 64'(1));
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    chk("starve_idle_vld", wb_vld, 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
